mavg_filter: RTL and testbench
==============================

MAVG_FILTER -- requirements
Module: mavg_filter

Interface
REQ-001 SHALL have parameter DW, default 16: signed sample width, input and output.
REQ-002 SHALL have parameter LOG2_N, default 3: window length N = 2**LOG2_N; legal range 1..8.
REQ-003 SHALL have parameter NCH, default 2: independent time-multiplexed channels, legal 1..16; CW = max(1, clog2(NCH)).
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: x_in/in_ch qualify this cycle.
REQ-007 SHALL have port in_ch, input, CW: channel index of the sample.
REQ-008 SHALL have port x_in, input, DW signed: sample.
REQ-009 SHALL have port out_valid, output, 1: y_out/out_ch/primed qualify this cycle.
REQ-010 SHALL have port out_ch, output, CW: channel of the result.
REQ-011 SHALL have port y_out, output, DW signed: window average.
REQ-012 SHALL have port primed, output, 1: the channel has received at least N samples since reset.
REQ-013 SHALL have port err, output, 1: single-cycle pulse when in_ch >= NCH.

Function
REQ-014 SHALL keep, per channel, an N-deep sample history (register-based), a write pointer, a running sum of width DW+LOG2_N+1, and a fill counter saturating at N.
REQ-015 SHALL, on an accepted sample, update sum_new = sum + x_in - oldest, store x_in over the oldest entry, and advance the pointer modulo N.
REQ-016 SHALL produce the result with a fixed latency of 1 cycle: out_valid, out_ch, y_out and primed are registered on the edge after in_valid.
REQ-017 SHALL compute y_out = sum_new >>> LOG2_N, truncating toward minus infinity, unless rounding is enabled (REQ-026).
REQ-018 SHALL saturate y_out to [-2**(DW-1), 2**(DW-1)-1].
REQ-019 SHALL sustain one sample per cycle, including back-to-back samples on the same channel, with no bubbles.
REQ-020 SHALL treat empty history entries as zero, so outputs before priming equal (sum of received samples)/N.
REQ-021 SHALL assert primed with the result of the N-th sample of a channel and hold it for that channel until reset.
REQ-022 SHALL, when in_ch >= NCH, drop the sample, leave all state unchanged, keep out_valid low, and pulse err the next cycle.
REQ-023 SHALL hold y_out, out_ch and primed stable while out_valid is low.

Reset
REQ-024 SHALL, while rst is high, clear all histories, sums, pointers and fill counters, and drive out_valid=0, out_ch=0, y_out=0, primed=0 and err=0; in_valid SHALL be ignored in that cycle.
REQ-025 SHALL, when rst is asserted mid-stream, discard the in-flight result; the first post-reset sample starts from an empty window.

Configuration
REQ-026 SHALL use macro MAVG_ROUND_EN: when defined, add 2**(LOG2_N-1) to sum_new before the shift (round half up); when undefined, truncate with no extra adder.

Structure
REQ-027 SHALL place the DW/LOG2_N/NCH defaults and the CW and sum-width derivation constants in shared package mavg_pkg.
REQ-028 SHALL implement the per-channel history and pointer in one sub-module, mavg_ring, instantiated NCH times; the accumulate, shift and saturate logic stays in mavg_filter.

Verification
All scenarios use DW=16, LOG2_N=2, NCH=2 unless stated.
REQ-029 SHALL cover a step: ch0 receives x=100 on 4 consecutive cycles -> y_out 25, 50, 75, 100, with primed first high on the 4th result.
REQ-030 SHALL cover rounding: ch0 receives single x=-2 -> y_out=-1 without MAVG_ROUND_EN and y_out=0 with it.
REQ-031 SHALL cover extremes: 8 samples of 32767 -> final y_out=32767; 8 samples of -32768 -> final y_out=-32768; no wrap, in both macro settings.
REQ-032 SHALL cover interleaving: ch0=100 and ch1=-100 alternating every cycle for 8 cycles -> ch0 results 25, 50, 75, 100 and ch1 results -25, -50, -75, -100, with out_ch matching.
REQ-033 SHALL cover a bad channel: NCH=3, in_ch=3 with x=500 -> err pulse, no out_valid, and the next valid ch0 sample x=40 -> y_out=10.
REQ-034 SHALL cover reset mid-stream: after 2 samples of 100 on ch0, rst high for 1 cycle, then x=40 on ch0 -> y_out=10, primed=0.

Source files
------------

// File: rtl/mavg_pkg.sv
// Shared constants and width helpers for the moving-average filter slice.
// Optional build feature: define MAVG_ROUND_EN for round-half-up averaging.
package mavg_pkg;

    localparam int DW_DEF     = 16;  // default signed sample width
    localparam int LOG2_N_DEF = 3;   // default log2 of the window length
    localparam int NCH_DEF    = 2;   // default number of multiplexed channels

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int cw_of(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Running-sum width: N full-scale samples plus one bit of rounding headroom.
    function automatic int sum_w(input int dw, input int log2n);
        return dw + log2n + 1;
    endfunction

endpackage

// File: rtl/mavg_ring.sv
// Per-channel N-deep sample history with a write pointer.
// oldest_o is the entry that the next accepted sample will overwrite.
module mavg_ring
    import mavg_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic signed [DW-1:0] wr_data_i,
    output logic signed [DW-1:0] oldest_o
);

    localparam int N = 2 ** LOG2_N;

    logic signed [DW-1:0] hist_q [N];
    logic [LOG2_N-1:0]    ptr_q;

    assign oldest_o = hist_q[ptr_q];

    // Pointer wraps naturally because the window length is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (wr_en_i) begin
            ptr_q <= ptr_q + LOG2_N'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            // Each entry clears to zero so an unfilled window averages in zeros.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hist_q[gi] <= '0;
                end else if (wr_en_i && (ptr_q == LOG2_N'(gi))) begin
                    hist_q[gi] <= wr_data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mavg_filter.sv
// Multi-channel moving-average filter, window N = 2**LOG2_N, one sample per
// cycle, result registered one cycle after the input.
// Optional build feature: define MAVG_ROUND_EN for round-half-up averaging;
// without it the average truncates toward minus infinity.
module mavg_filter
    import mavg_pkg::*;
#(
    parameter  int DW     = DW_DEF,
    parameter  int LOG2_N = LOG2_N_DEF,
    parameter  int NCH    = NCH_DEF,
    localparam int CW     = cw_of(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_ch,
    input  logic signed [DW-1:0] x_in,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic signed [DW-1:0] y_out,
    output logic                 primed,
    output logic                 err
);

    localparam int N  = 2 ** LOG2_N;
    localparam int SW = sum_w(DW, LOG2_N);
    localparam int FW = LOG2_N + 1;

    localparam logic signed [SW-1:0] Y_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] Y_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic                 ch_ok;
    logic                 accept;
    logic [CW-1:0]        ch_sel;
    logic signed [DW-1:0] oldest_w [NCH];
    logic signed [SW-1:0] sum_q    [NCH];
    logic [FW-1:0]        fill_q   [NCH];

    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] rnd_d;
    logic signed [SW-1:0] shift_d;
    logic signed [DW-1:0] y_d;
    logic [FW-1:0]        fill_d;
    logic                 primed_d;

    logic                 out_valid_q;
    logic [CW-1:0]        out_ch_q;
    logic signed [DW-1:0] y_q;
    logic                 primed_q;
    logic                 err_q;

    assign ch_ok  = ({1'b0, in_ch} < (CW+1)'(NCH));
    assign accept = in_valid && ch_ok && !rst;
    // Out-of-range indices never commit, so any legal index is safe to read.
    assign ch_sel = ch_ok ? in_ch : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic wr_en;
            assign wr_en = accept && (in_ch == CW'(gi));

            mavg_ring #(
                .DW     (DW),
                .LOG2_N (LOG2_N)
            ) u_ring (
                .clk       (clk),
                .rst       (rst),
                .wr_en_i   (wr_en),
                .wr_data_i (x_in),
                .oldest_o  (oldest_w[gi])
            );

            // Running sum and saturating fill count for this channel.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_q[gi]  <= '0;
                    fill_q[gi] <= '0;
                end else if (wr_en) begin
                    sum_q[gi]  <= sum_d;
                    fill_q[gi] <= fill_d;
                end
            end
        end
    endgenerate

    // Accumulate, optionally round, shift by LOG2_N and clamp to DW bits.
    always_comb begin
        sum_d = sum_q[ch_sel] + SW'(x_in) - SW'(oldest_w[ch_sel]);
`ifdef MAVG_ROUND_EN
        rnd_d = sum_d + (SW'(1) <<< (LOG2_N - 1));
`else
        rnd_d = sum_d;
`endif
        shift_d = rnd_d >>> LOG2_N;
        if (shift_d > Y_MAX) begin
            y_d = Y_MAX[DW-1:0];
        end else if (shift_d < Y_MIN) begin
            y_d = Y_MIN[DW-1:0];
        end else begin
            y_d = shift_d[DW-1:0];
        end
        fill_d   = (fill_q[ch_sel] == FW'(N)) ? FW'(N) : fill_q[ch_sel] + FW'(1);
        primed_d = (fill_d == FW'(N));
    end

    // Result register; data fields only move on an accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            y_q         <= '0;
            primed_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= accept;
            err_q       <= in_valid && !ch_ok;
            if (accept) begin
                out_ch_q <= in_ch;
                y_q      <= y_d;
                primed_q <= primed_d;
            end
        end
    end

    // Outputs read as zero during reset so an in-flight result is discarded.
    assign out_valid = out_valid_q && !rst;
    assign out_ch    = rst ? '0 : out_ch_q;
    assign y_out     = rst ? '0 : y_q;
    assign primed    = primed_q && !rst;
    assign err       = err_q && !rst;

endmodule

// File: tb/tb_mavg_filter.sv
// Self-checking bench for mavg_filter: constant vector table, directed corner
// sequences and a randomized stream against a queue-based window model.
module tb_mavg_filter;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [0:0]         in_ch;
    logic signed [15:0] x_in;
    logic               out_valid;
    logic [0:0]         out_ch;
    logic signed [15:0] y_out;
    logic               primed;
    logic               err;

    logic               in_valid3;
    logic [1:0]         in_ch3;
    logic signed [15:0] x_in3;
    logic               out_valid3;
    logic [1:0]         out_ch3;
    logic signed [15:0] y_out3;
    logic               primed3;
    logic               err3;

    mavg_filter #(.DW(16), .LOG2_N(2), .NCH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .x_in(x_in),
        .out_valid(out_valid), .out_ch(out_ch), .y_out(y_out), .primed(primed), .err(err)
    );

    mavg_filter #(.DW(16), .LOG2_N(2), .NCH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ch(in_ch3), .x_in(x_in3),
        .out_valid(out_valid3), .out_ch(out_ch3), .y_out(y_out3), .primed(primed3), .err(err3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int ch, input int x);
        in_valid = v;
        in_ch    = ch[0:0];
        x_in     = x[15:0];
    endtask

    // ---------------- reference model: last N samples per channel ----------
    int q0[$];
    int q1[$];
    int m_cnt[2];

    function automatic int avg_of(input int s);
        int t;
        int r;
        t = s;
`ifdef MAVG_ROUND_EN
        t = t + N / 2;
`endif
        if (t >= 0) r = t / N;
        else        r = -((-t + N - 1) / N);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic m_reset();
        q0.delete();
        q1.delete();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic m_push(input int ch, input int x, output int y, output bit pr);
        int s;
        s = 0;
        if (ch == 0) begin
            q0.push_back(x);
            if (q0.size() > N) void'(q0.pop_front());
            foreach (q0[k]) s += q0[k];
        end else begin
            q1.push_back(x);
            if (q1.size() > N) void'(q1.pop_front());
            foreach (q1[k]) s += q1[k];
        end
        m_cnt[ch]++;
        y  = avg_of(s);
        pr = (m_cnt[ch] >= N);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;     // must be ignored while in reset
        in_ch     = 1'b0;
        x_in      = 16'sd123;
        in_valid3 = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_primed", primed, 0);
        chk("rst_err", err, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        m_reset();
    endtask

    // ---------------- constant vector table --------------------------------
    typedef struct {
        bit do_rst;
        bit v;
        int ch;
        int x;
        bit e_v;
        int e_ch;
        int e_y;
        bit e_pr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int  y_m;
        bit  pr_m;
        int  last_y;
        int  last_ch;
        bit  last_pr;
        int  exp_rnd;

        rst = 1'b1; in_valid = 1'b0; in_ch = 1'b0; x_in = '0;
        in_valid3 = 1'b0; in_ch3 = '0; x_in3 = '0;
        m_reset();

        // step on ch0, then an idle cycle that must hold the last result
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 25, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 50, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 75, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 100, 1});
        tbl.push_back('{0, 0, 0, 7, 0, 0, 100, 1});
        // interleaved channels, back-to-back
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 25, 0});
        tbl.push_back('{0, 1, 1, -100, 1, 1, -25, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 50, 0});
        tbl.push_back('{0, 1, 1, -100, 1, 1, -50, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 75, 0});
        tbl.push_back('{0, 1, 1, -100, 1, 1, -75, 0});
        tbl.push_back('{0, 1, 0, 100, 1, 0, 100, 1});
        tbl.push_back('{0, 1, 1, -100, 1, 1, -100, 1});

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) begin
                do_reset();
            end else begin
                drive(tbl[i].v, tbl[i].ch, tbl[i].x);
                tick();
                chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_v);
                chk($sformatf("tbl%0d_y", i), y_out, tbl[i].e_y);
                chk($sformatf("tbl%0d_ch", i), out_ch, tbl[i].e_ch);
                chk($sformatf("tbl%0d_primed", i), primed, tbl[i].e_pr);
            end
        end
        drive(0, 0, 0);

        // rounding of a single negative sample
        do_reset();
`ifdef MAVG_ROUND_EN
        exp_rnd = 0;
`else
        exp_rnd = -1;
`endif
        drive(1, 0, -2);
        tick();
        chk("round_valid", out_valid, 1);
        chk("round_y", y_out, exp_rnd);
        drive(0, 0, 0);

        // full-scale extremes, no wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32767);
            tick();
            m_push(0, 32767, y_m, pr_m);
            chk($sformatf("maxpos%0d_y", i), y_out, y_m);
        end
        chk("maxpos_final", y_out, 32767);
        chk("maxpos_primed", primed, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, -32768);
            tick();
            m_push(0, -32768, y_m, pr_m);
            chk($sformatf("maxneg%0d_y", i), y_out, y_m);
        end
        chk("maxneg_final", y_out, -32768);
        drive(0, 0, 0);

        // bad channel on a 3-channel instance
        do_reset();
        in_valid3 = 1'b1; in_ch3 = 2'd3; x_in3 = 16'sd500;
        tick();
        chk("badch_err", err3, 1);
        chk("badch_valid", out_valid3, 0);
        in_ch3 = 2'd0; x_in3 = 16'sd40;
        tick();
        chk("badch_next_err", err3, 0);
        chk("badch_next_valid", out_valid3, 1);
        chk("badch_next_y", y_out3, 10);
        chk("badch_next_ch", out_ch3, 0);
        chk("badch_next_primed", primed3, 0);
        in_valid3 = 1'b0;
        tick();
        chk("badch_idle_valid", out_valid3, 0);
        chk("badch_idle_err", err3, 0);

        // reset in the middle of a stream
        do_reset();
        drive(1, 0, 100);
        tick();
        chk("midrst_y1", y_out, 25);
        drive(1, 0, 100);
        rst = 1'b1;
        tick();
        chk("midrst_discard_valid", out_valid, 0);
        chk("midrst_discard_y", y_out, 0);
        rst = 1'b0;
        m_reset();
        drive(1, 0, 40);
        tick();
        chk("midrst_after_valid", out_valid, 1);
        chk("midrst_after_y", y_out, 10);
        chk("midrst_after_primed", primed, 0);
        drive(0, 0, 0);

        // randomized stream against the window model
        do_reset();
        last_y = 0; last_ch = 0; last_pr = 0;
        for (int i = 0; i < 400; i++) begin
            bit v;
            int ch;
            int x;
            v  = ($urandom_range(0, 3) != 0);
            ch = $urandom_range(0, 1);
            x  = $urandom_range(0, 65535) - 32768;
            if ($urandom_range(0, 7) == 0) x = (ch == 1) ? 32767 : -32768;
            drive(v, ch, x);
            tick();
            if (v) begin
                m_push(ch, x, y_m, pr_m);
                last_y = y_m; last_ch = ch; last_pr = pr_m;
                chk($sformatf("rnd%0d_valid", i), out_valid, 1);
            end else begin
                chk($sformatf("rnd%0d_valid", i), out_valid, 0);
            end
            chk($sformatf("rnd%0d_y", i), y_out, last_y);
            chk($sformatf("rnd%0d_ch", i), out_ch, last_ch);
            chk($sformatf("rnd%0d_primed", i), primed, last_pr);
            chk($sformatf("rnd%0d_err", i), err, 0);
        end
        drive(0, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
